// File: rtl/usb_rx_bit_decoder.sv
// rtl/usb_rx_bit_decoder.sv - USB full-speed RX front end: sync, bit timing, NRZI, unstuff, EOP, bytes
// Optional macro RX_STUFF_CHECK_EN: a stuff-position bit that decodes as 1 raises rx_bit_error.
module usb_rx_bit_decoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus_in,
  input  logic       d_minus_in,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       rx_active,
  output logic       eop,
  output logic       rx_bit_error
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LP_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LP_HALF = CW'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_EOP1,
    S_EOP2,
    S_WAIT_EOP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic          r_dp_s1;
  logic          r_dp_s2;
  logic          r_dm_s1;
  logic          r_dm_s2;
  logic          r_dp_prev;
  logic [CW-1:0] r_cnt;

  logic          r_prev_j;
  logic [2:0]    r_run;
  logic [2:0]    r_bcnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_rx_byte;
  logic [1:0]    r_se0_cnt;
  logic          r_byte_valid;
  logic          r_eop;
  logic          r_err;
  logic          r_rx_active;

  logic          w_edge;
  logic          w_sample;
  logic          w_sym_j;
  logic          w_sym_k;
  logic          w_sym_se0;
  logic          w_bit;
  logic [7:0]    w_shift_in;

  logic          w_prev_j_nxt;
  logic [2:0]    w_run_nxt;
  logic [2:0]    w_bcnt_nxt;
  logic [7:0]    w_shift_nxt;
  logic [7:0]    w_rx_byte_nxt;
  logic [1:0]    w_se0_cnt_nxt;
  logic          w_byte_valid_nxt;
  logic          w_eop_nxt;
  logic          w_err_nxt;
  logic          w_rx_active_nxt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_dp_s1   <= 1'b1;
      r_dp_s2   <= 1'b1;
      r_dp_prev <= 1'b1;
      r_dm_s1   <= 1'b0;
      r_dm_s2   <= 1'b0;
    end else begin
      r_dp_s1   <= d_plus_in;
      r_dp_s2   <= r_dp_s1;
      r_dp_prev <= r_dp_s2;
      r_dm_s1   <= d_minus_in;
      r_dm_s2   <= r_dm_s1;
    end
  end

  assign w_edge   = r_dp_s2 ^ r_dp_prev;
  assign w_sample = (r_cnt == LP_HALF);

  // Every D+ transition recentres the bit timer so sampling stays mid-bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (w_edge || (r_cnt == LP_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_sym_j    = r_dp_s2 & ~r_dm_s2;
  assign w_sym_k    = ~r_dp_s2 & r_dm_s2;
  assign w_sym_se0  = ~(w_sym_j | w_sym_k);
  assign w_bit      = (w_sym_j == r_prev_j);
  assign w_shift_in = {w_bit, r_shift[7:1]};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_prev_j_nxt     = r_prev_j;
    w_run_nxt        = r_run;
    w_bcnt_nxt       = r_bcnt;
    w_shift_nxt      = r_shift;
    w_rx_byte_nxt    = r_rx_byte;
    w_se0_cnt_nxt    = r_se0_cnt;
    w_byte_valid_nxt = 1'b0;
    w_eop_nxt        = 1'b0;
    w_err_nxt        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_prev_j_nxt  = 1'b1;
        w_run_nxt     = '0;
        w_bcnt_nxt    = '0;
        w_se0_cnt_nxt = '0;
        if (w_edge && w_sym_k) begin
          w_state_nxt = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        if (w_sample) begin
          if (w_sym_se0) begin
            w_state_nxt = S_EOP1;
          end else begin
            w_prev_j_nxt = w_sym_j;
            if (r_run == 3'd6) begin
              w_run_nxt = '0;
`ifdef RX_STUFF_CHECK_EN
              if (w_bit) begin
                w_err_nxt     = 1'b1;
                w_se0_cnt_nxt = '0;
                w_state_nxt   = S_WAIT_EOP;
              end
`endif
            end else begin
              w_run_nxt   = w_bit ? (r_run + 3'd1) : 3'd0;
              w_shift_nxt = w_shift_in;
              w_bcnt_nxt  = r_bcnt + 3'd1;
              if (r_bcnt == 3'd7) begin
                w_rx_byte_nxt    = w_shift_in;
                w_byte_valid_nxt = 1'b1;
              end
            end
          end
        end
      end

      S_EOP1: begin
        if (w_sample) begin
          if (w_sym_se0) begin
            w_state_nxt = S_EOP2;
          end else begin
            w_err_nxt     = 1'b1;
            w_se0_cnt_nxt = '0;
            w_state_nxt   = S_WAIT_EOP;
          end
        end
      end

      S_EOP2: begin
        if (w_sample) begin
          if (w_sym_j) begin
            // A leftover partial byte is dropped and flagged alongside the EOP.
            w_eop_nxt   = 1'b1;
            w_err_nxt   = (r_bcnt != 3'd0);
            w_state_nxt = S_IDLE;
          end else if (w_sym_k) begin
            w_err_nxt     = 1'b1;
            w_se0_cnt_nxt = '0;
            w_state_nxt   = S_WAIT_EOP;
          end
        end
      end

      S_WAIT_EOP: begin
        if (w_sample) begin
          if (w_sym_se0) begin
            w_se0_cnt_nxt = (r_se0_cnt == 2'd2) ? 2'd2 : (r_se0_cnt + 2'd1);
          end else if (w_sym_j && (r_se0_cnt == 2'd2)) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_se0_cnt_nxt = '0;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_rx_active_nxt = (w_state_nxt == S_ACTIVE) || (w_state_nxt == S_EOP1) ||
                      (w_state_nxt == S_EOP2);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_prev_j     <= 1'b1;
      r_run        <= '0;
      r_bcnt       <= '0;
      r_shift      <= '0;
      r_rx_byte    <= '0;
      r_se0_cnt    <= '0;
      r_byte_valid <= 1'b0;
      r_eop        <= 1'b0;
      r_err        <= 1'b0;
      r_rx_active  <= 1'b0;
    end else begin
      r_prev_j     <= w_prev_j_nxt;
      r_run        <= w_run_nxt;
      r_bcnt       <= w_bcnt_nxt;
      r_shift      <= w_shift_nxt;
      r_rx_byte    <= w_rx_byte_nxt;
      r_se0_cnt    <= w_se0_cnt_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_eop        <= w_eop_nxt;
      r_err        <= w_err_nxt;
      r_rx_active  <= w_rx_active_nxt;
    end
  end

  assign rx_byte      = r_rx_byte;
  assign byte_valid   = r_byte_valid;
  assign rx_active    = r_rx_active;
  assign eop          = r_eop;
  assign rx_bit_error = r_err;

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// tb/tb_usb_rx_bit_decoder.sv - directed-packet bench for usb_rx_bit_decoder with a symbol-level model
// Honours RX_STUFF_CHECK_EN the same way the design does.
module tb_usb_rx_bit_decoder;

  localparam int SJ = 0, SK = 1, SSE0 = 2;
  localparam int EV_BYTE = 1, EV_EOP = 2, EV_ERR = 3, EV_EOPERR = 4, EV_BAD = 9;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_plus_in = 1'b1;
  logic       d_minus_in = 1'b0;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       rx_active;
  logic       eop;
  logic       rx_bit_error;

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  ev_t  exp_q[$];
  int   wire_bits[$];
  int   syms[$];
  int   run_len = 0;
  int   t_k = 0, t_act = -1, t_bv = -1, t_eop = -1;
  logic prev_act = 1'b0;

  usb_rx_bit_decoder #(.CLKS_PER_BIT(8)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_plus_in    (d_plus_in),
    .d_minus_in   (d_minus_in),
    .rx_byte      (rx_byte),
    .byte_valid   (byte_valid),
    .rx_active    (rx_active),
    .eop          (eop),
    .rx_bit_error (rx_bit_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
  endtask

  function automatic void push_ev(input int kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endfunction

  task automatic clear_pkt();
    wire_bits.delete();
    syms.delete();
    run_len = 0;
  endtask

  // Appends n bits LSB-first; with stuff set, a 0 is inserted after six 1s in a row.
  task automatic add_bits(input logic [7:0] v, input int n, input bit stuff);
    for (int i = 0; i < n; i++) begin
      int b;
      b = v[i] ? 1 : 0;
      wire_bits.push_back(b);
      if (stuff) begin
        run_len = (b == 1) ? run_len + 1 : 0;
        if (run_len == 6) begin
          wire_bits.push_back(0);
          run_len = 0;
        end
      end
    end
  endtask

  task automatic encode();
    int level;
    level = SJ;
    syms.delete();
    foreach (wire_bits[i]) begin
      if (wire_bits[i] == 0) level = (level == SJ) ? SK : SJ;
      syms.push_back(level);
    end
    syms.push_back(SSE0);
    syms.push_back(SSE0);
    syms.push_back(SJ);
  endtask

  // Whole-packet model: NRZI-decode up to the first SE0, strip stuff bits, chunk into bytes.
  function automatic void model();
    int         prev;
    int         e;
    int         run;
    int         bits[$];
    int         data[$];
    bit         serr;
    logic [7:0] by;
    prev = SJ;
    e    = 0;
    run  = 0;
    serr = 1'b0;
    while (e < syms.size() && syms[e] != SSE0) begin
      bits.push_back((syms[e] == prev) ? 1 : 0);
      prev = syms[e];
      e++;
    end
    foreach (bits[i]) begin
      if (run == 6) begin
        run = 0;
`ifdef RX_STUFF_CHECK_EN
        if (bits[i] == 1) begin
          serr = 1'b1;
          break;
        end
`endif
      end else begin
        data.push_back(bits[i]);
        run = (bits[i] == 1) ? run + 1 : 0;
      end
    end
    for (int j = 0; j + 8 <= data.size(); j += 8) begin
      by = '0;
      for (int k = 0; k < 8; k++) by[k] = (data[j+k] != 0);
      push_ev(EV_BYTE, by);
    end
    if (serr) push_ev(EV_ERR, 8'h00);
    else if (e + 2 < syms.size() && syms[e+1] == SSE0 && syms[e+2] == SJ)
      push_ev(((data.size() % 8) != 0) ? EV_EOPERR : EV_EOP, 8'h00);
  endfunction

  task automatic drive_sym(input int s, input int n);
    d_plus_in  = (s == SJ);
    d_minus_in = (s == SK);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic send(input bit jit, input string name);
    t_act = -1;
    t_bv  = -1;
    t_eop = -1;
    t_k   = cyc;
    foreach (syms[i]) drive_sym(syms[i], jit ? (((i % 2) != 0) ? 9 : 7) : 8);
    drive_sym(SJ, 40);
    wait_drain(name);
  endtask

  task automatic build_clean();
    clear_pkt();
    add_bits(8'h80, 8, 1'b1);
    add_bits(8'hA5, 8, 1'b1);
    encode();
  endtask

  initial begin : compare
    ev_t e;
    int  k;
    forever begin
      @(negedge clk);
      if (rx_active && !prev_act) t_act = cyc;
      prev_act = rx_active;
      if (byte_valid || eop || rx_bit_error) begin
        if (byte_valid) k = (eop || rx_bit_error) ? EV_BAD : EV_BYTE;
        else if (eop) k = rx_bit_error ? EV_EOPERR : EV_EOP;
        else k = EV_ERR;
        if (byte_valid && t_bv < 0) t_bv = cyc;
        if (eop) t_eop = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", k, 0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", k, e.kind);
          if (k == EV_BYTE) chk("rx_byte", int'(rx_byte), int'(e.val));
        end
        if (byte_valid) chk("active_with_byte", int'(rx_active), 1);
        if (eop) chk("active_low_at_eop", int'(rx_active), 0);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (4) @(negedge clk);
    chk("rst_rx_byte", int'(rx_byte), 0);
    chk("rst_byte_valid", int'(byte_valid), 0);
    chk("rst_eop", int'(eop), 0);
    chk("rst_bit_error", int'(rx_bit_error), 0);
    chk("rst_rx_active", int'(rx_active), 0);
    n_rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_rx_active", int'(rx_active), 0);

    // Clean packet, nominal timing
    build_clean();
    model();
    chk("model_clean_n", exp_q.size(), 3);
    chk("model_clean_b0", int'(exp_q[0].val), 8'h80);
    chk("model_clean_b1", int'(exp_q[1].val), 8'hA5);
    chk("model_clean_eop", exp_q[2].kind, EV_EOP);
    send(1'b0, "clean_drain");
    chk("lat_rx_active", t_act - t_k, 3);
    chk("lat_byte_valid", t_bv - t_k, 64);
    chk("lat_eop", t_eop - t_k, 152);
    chk("rx_byte_hold", int'(rx_byte), 8'hA5);
    chk("idle_after_clean", int'(rx_active), 0);

    // Stuffed 0xFF 0x01
    clear_pkt();
    add_bits(8'h80, 8, 1'b1);
    add_bits(8'hFF, 8, 1'b1);
    add_bits(8'h01, 8, 1'b1);
    encode();
    chk("stuff_wire_len", wire_bits.size(), 25);
    model();
    chk("model_stuff_n", exp_q.size(), 4);
    chk("model_stuff_b1", int'(exp_q[1].val), 8'hFF);
    chk("model_stuff_b2", int'(exp_q[2].val), 8'h01);
    send(1'b0, "stuff_drain");

    // Seven raw 1s after SYNC, no stuff bit inserted
    clear_pkt();
    add_bits(8'h80, 8, 1'b1);
    add_bits(8'h7F, 7, 1'b0);
    add_bits(8'h00, 2, 1'b0);
    encode();
    model();
    send(1'b0, "violation_drain");
    chk("violation_idle", int'(rx_active), 0);

    // Partial byte before EOP
    clear_pkt();
    add_bits(8'h80, 8, 1'b1);
    add_bits(8'h0D, 5, 1'b1);
    encode();
    model();
    chk("model_partial_n", exp_q.size(), 2);
    chk("model_partial_kind", exp_q[1].kind, EV_EOPERR);
    send(1'b0, "partial_drain");

    // Clean packet with 7/9 clock bit periods
    build_clean();
    model();
    send(1'b1, "skew_drain");

    // Reset in the middle of 0xA5
    build_clean();
    push_ev(EV_BYTE, 8'h80);
    for (int i = 0; i < 12; i++) drive_sym(syms[i], 8);
    chk("midpkt_byte_seen", exp_q.size(), 0);
    chk("midpkt_active", int'(rx_active), 1);
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    d_plus_in  = 1'b1;
    d_minus_in = 1'b0;
    #1;
    chk("async_rst_rx_byte", int'(rx_byte), 0);
    chk("async_rst_active", int'(rx_active), 0);
    chk("async_rst_strobes", int'({byte_valid, eop, rx_bit_error}), 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (20) @(negedge clk);
    exp_q.delete();
    build_clean();
    model();
    send(1'b0, "post_reset_drain");
    chk("post_reset_rx_byte", int'(rx_byte), 8'hA5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
